// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// FifoUartTx -- FIFO drain that serialises each popped entry as a UART frame.
//
// Pops one entry at a time from the edge-strobed byte FIFO with a single-cycle
// read strobe and shifts it out on the TX pin. Frame format: 1 start bit,
// DATA_WIDTH data bits LSB first, STOP_BITS stop bits, no parity.
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   asynchronous, active-high reset
//   enable      in   allows new frames to start
//   fifo_empty  in   FIFO empty flag, only looked at while idle
//   fifo_data   in   FIFO head entry, valid when fifo_empty is low
//   fifo_rd_en  out  one-cycle pop strobe, asserted as a frame starts
//   tx          out  serial line, idle high
//   busy        out  high from the start bit through the last stop bit
//   frame_done  out  one-cycle pulse as the last stop bit ends
// ---------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int CLK_FREQ     = 27000000,
    parameter int BAUD         = 115200,
    parameter int DATA_WIDTH   = 8,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                r_state;
    state_t                w_stateNext;
    logic [BAUD_W-1:0]     r_baudCnt;
    logic [BAUD_W-1:0]     w_baudCntNext;
    logic [BIT_W-1:0]      r_bitCnt;
    logic [BIT_W-1:0]      w_bitCntNext;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shiftNext;
    logic                  r_tx;
    logic                  w_txNext;
    logic                  r_busy;
    logic                  w_busyNext;
    logic                  r_rdEn;
    logic                  w_rdEnNext;
    logic                  r_frameDone;
    logic                  w_frameDoneNext;
    logic                  w_bitEnd;

    // Last clock of the current bit period.
    assign w_bitEnd = (r_baudCnt == BAUD_LAST);

    assign fifo_rd_en = r_rdEn;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_frameDone;

    // State and every output are registered; reset forces the line idle
    // (high) immediately, discarding whatever byte was in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_baudCnt   <= '0;
            r_bitCnt    <= '0;
            r_shift     <= '0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_rdEn      <= 1'b0;
            r_frameDone <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_baudCnt   <= w_baudCntNext;
            r_bitCnt    <= w_bitCntNext;
            r_shift     <= w_shiftNext;
            r_tx        <= w_txNext;
            r_busy      <= w_busyNext;
            r_rdEn      <= w_rdEnNext;
            r_frameDone <= w_frameDoneNext;
        end
    end

    // Next-state and next-output logic. The FIFO head is captured on the
    // same edge that raises the pop strobe, so the data is taken before the
    // FIFO advances its pointer. The data bit is presented from bit 0 of the
    // shift register as it shifts right, and tx is updated on the same edge
    // that starts each bit so the line changes exactly at bit boundaries.
    always_comb begin
        w_stateNext     = r_state;
        w_baudCntNext   = r_baudCnt;
        w_bitCntNext    = r_bitCnt;
        w_shiftNext     = r_shift;
        w_txNext        = r_tx;
        w_busyNext      = r_busy;
        w_rdEnNext      = 1'b0;
        w_frameDoneNext = 1'b0;

        case (r_state)
            IDLE: begin
                w_txNext   = 1'b1;
                w_busyNext = 1'b0;
                if (enable && !fifo_empty) begin
                    w_stateNext   = START;
                    w_shiftNext   = fifo_data;
                    w_rdEnNext    = 1'b1;
                    w_txNext      = 1'b0;
                    w_busyNext    = 1'b1;
                    w_baudCntNext = '0;
                    w_bitCntNext  = '0;
                end
            end

            START: begin
                if (w_bitEnd) begin
                    w_stateNext   = DATA;
                    w_baudCntNext = '0;
                    w_bitCntNext  = '0;
                    w_txNext      = r_shift[0];
                    w_shiftNext   = r_shift >> 1;
                end else begin
                    w_baudCntNext = r_baudCnt + 1'b1;
                end
            end

            DATA: begin
                if (w_bitEnd) begin
                    w_baudCntNext = '0;
                    if (r_bitCnt == DATA_LAST) begin
                        w_stateNext  = STOP;
                        w_bitCntNext = '0;
                        w_txNext     = 1'b1;
                    end else begin
                        w_bitCntNext = r_bitCnt + 1'b1;
                        w_txNext     = r_shift[0];
                        w_shiftNext  = r_shift >> 1;
                    end
                end else begin
                    w_baudCntNext = r_baudCnt + 1'b1;
                end
            end

            STOP: begin
                if (w_bitEnd) begin
                    w_baudCntNext = '0;
                    if (r_bitCnt == STOP_LAST) begin
                        w_stateNext     = IDLE;
                        w_bitCntNext    = '0;
                        w_busyNext      = 1'b0;
                        w_frameDoneNext = 1'b1;
                    end else begin
                        w_bitCntNext = r_bitCnt + 1'b1;
                    end
                end else begin
                    w_baudCntNext = r_baudCnt + 1'b1;
                end
            end

            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_fifo_uart_tx -- self-checking bench for fifo_uart_tx.
//
// A frame-level model predicts tx/busy/fifo_rd_en/frame_done every cycle from
// the frame start time and the popped byte. A simple array FIFO feeds the
// main instance, a UART monitor decodes the line, and a second instance with
// two stop bits is exercised with a fixed byte.
// ---------------------------------------------------------------------------
module tb_fifo_uart_tx;

    localparam int CPB    = 16;
    localparam int FRAME1 = 10 * CPB;
    localparam int FRAME2 = 11 * CPB;
    localparam int MASK   = 8191;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       fifoEmpty;
    logic [7:0] fifoData;
    logic       fifoRdEn;
    logic       tx;
    logic       busy;
    logic       frameDone;

    logic       enable2;
    logic       fifoEmpty2;
    logic [7:0] fifoData2;
    logic       fifoRdEn2;
    logic       tx2;
    logic       busy2;
    logic       frameDone2;

    // Array FIFO for the main instance; the bench pushes, the pop strobe pops.
    logic [7:0] fifoMem [0:255];
    int         wrIdx;
    int         rdIdx;

    assign fifoEmpty = (wrIdx == rdIdx);
    assign fifoData  = fifoMem[rdIdx[7:0]];

    fifo_uart_tx #(
        .CLK_FREQ(1600), .BAUD(100), .DATA_WIDTH(8), .STOP_BITS(1)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .fifo_empty(fifoEmpty), .fifo_data(fifoData),
        .fifo_rd_en(fifoRdEn), .tx(tx), .busy(busy), .frame_done(frameDone)
    );

    fifo_uart_tx #(
        .CLK_FREQ(1600), .BAUD(100), .DATA_WIDTH(8), .STOP_BITS(2)
    ) dut2 (
        .clock(clock), .reset(reset), .enable(enable2),
        .fifo_empty(fifoEmpty2), .fifo_data(fifoData2),
        .fifo_rd_en(fifoRdEn2), .tx(tx2), .busy(busy2), .frame_done(frameDone2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checkCount;
    int passCount;
    int cycleNo;

    // Frame-level model of the main instance.
    bit         mIn;
    int         mN;
    logic [7:0] mByte;
    bit         popPending;

    // Line monitor.
    bit         monActive;
    int         monCnt;
    logic [7:0] monByte;
    logic       prevTx;

    logic txLog    [0:MASK];
    logic busyLog  [0:MASK];
    logic tx2Log   [0:MASK];
    logic busy2Log [0:MASK];

    int         strobeCount;
    int         doneCount;
    int         strobe2Count;
    int         startQ[$];
    int         doneQ[$];
    logic [7:0] decodedQ[$];

    int st;
    int dn;
    int s0;
    int c0;
    int d0;
    int cnt;
    int guard;

    int segA5 [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int segF0 [9]  = '{0, 0, 0, 0, 0, 1, 1, 1, 1};

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] required);
        checkCount++;
        if (actual === required) passCount++;
        else $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)",
                      name, actual, required, cycleNo);
    endtask

    // Line level at cycle n of a frame carrying byte b (n=0 is the first
    // start-bit cycle).
    function automatic logic modelTx(input int n, input logic [7:0] b);
        int seg;
        seg = n / CPB;
        if (seg == 0) return 1'b0;
        if (seg <= 8) return b[seg-1];
        return 1'b1;
    endfunction

    function automatic logic txAt(input int c);
        return txLog[c & MASK];
    endfunction

    function automatic logic busyAt(input int c);
        return busyLog[c & MASK];
    endfunction

    function automatic logic tx2At(input int c);
        return tx2Log[c & MASK];
    endfunction

    function automatic logic busy2At(input int c);
        return busy2Log[c & MASK];
    endfunction

    task automatic pushByte(input logic [7:0] b);
        fifoMem[wrIdx[7:0]] = b;
        wrIdx++;
    endtask

    // Called once per cycle at the falling edge: advances the model by the
    // rising edge that just happened, compares, then lets the FIFO react.
    task automatic checkOutput();
        logic eTx;
        logic eBusy;
        logic eRd;
        logic eDone;
        cycleNo++;
        eTx   = 1'b1;
        eBusy = 1'b0;
        eRd   = 1'b0;
        eDone = 1'b0;
        if (reset) begin
            mIn        = 1'b0;
            popPending = 1'b0;
        end else if (mIn) begin
            mN++;
            if (mN == FRAME1) begin
                mIn   = 1'b0;
                eDone = 1'b1;
            end else begin
                eTx   = modelTx(mN, mByte);
                eBusy = 1'b1;
            end
        end else if (enable && !fifoEmpty) begin
            mIn   = 1'b1;
            mN    = 0;
            mByte = fifoData;
            eTx   = 1'b0;
            eBusy = 1'b1;
            eRd   = 1'b1;
        end
        check("tx", tx, eTx);
        check("busy", busy, eBusy);
        check("fifo_rd_en", fifoRdEn, eRd);
        check("frame_done", frameDone, eDone);

        if (!reset) begin
            if (popPending) rdIdx++;
            popPending = fifoRdEn;
        end

        if (fifoRdEn) begin
            strobeCount++;
            startQ.push_back(cycleNo);
        end
        if (frameDone) begin
            doneCount++;
            doneQ.push_back(cycleNo);
        end
        txLog[cycleNo & MASK]   = tx;
        busyLog[cycleNo & MASK] = busy;

        if (reset) begin
            monActive = 1'b0;
        end else if (!monActive) begin
            if (prevTx && !tx) begin
                monActive = 1'b1;
                monCnt    = 0;
            end
        end else begin
            monCnt++;
            if ((monCnt % CPB) == 8 && (monCnt / CPB) >= 1 && (monCnt / CPB) <= 8)
                monByte[monCnt/CPB - 1] = tx;
            if (monCnt == 9 * CPB + 8) begin
                check("monitor stop bit", tx, 1);
                check("monitor byte vs model", monByte, mByte);
                decodedQ.push_back(monByte);
                monActive = 1'b0;
            end
        end
        prevTx = tx;

        tx2Log[cycleNo & MASK]   = tx2;
        busy2Log[cycleNo & MASK] = busy2;
        if (fifoRdEn2) begin
            strobe2Count++;
            fifoEmpty2 = 1'b1;
        end
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(negedge clock);
            checkOutput();
        end
    endtask

    // sel: 0 pop strobe, 1 frame_done, 2 pop strobe (2 stop), 3 frame_done (2 stop)
    task automatic waitFor(input int sel, input int maxCycles, input string name,
                           output int at);
        at = -1;
        for (int i = 0; i < maxCycles; i++) begin
            applyStimulus(1);
            if ((sel == 0 && fifoRdEn) || (sel == 1 && frameDone) ||
                (sel == 2 && fifoRdEn2) || (sel == 3 && frameDone2)) begin
                at = cycleNo;
                break;
            end
        end
        check({name, " seen"}, (at >= 0), 1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycleNo);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checkCount = 0; passCount = 0; cycleNo = 0;
        mIn = 1'b0; mN = 0; mByte = 8'h00; popPending = 1'b0;
        monActive = 1'b0; monCnt = 0; monByte = 8'h00; prevTx = 1'b1;
        strobeCount = 0; doneCount = 0; strobe2Count = 0;
        wrIdx = 0; rdIdx = 0;
        reset = 1'b1; enable = 1'b0;
        enable2 = 1'b0; fifoEmpty2 = 1'b1; fifoData2 = 8'hF0;

        // Reset values.
        #1;
        check("reset tx", tx, 1);
        check("reset busy", busy, 0);
        check("reset fifo_rd_en", fifoRdEn, 0);
        check("reset frame_done", frameDone, 0);
        applyStimulus(3);

        // 1: empty FIFO, enabled -> idle line for 500 cycles.
        $display("[TB] scenario 1: idle with empty FIFO");
        reset = 1'b0; enable = 1'b1;
        s0 = strobeCount; c0 = cycleNo;
        applyStimulus(500);
        cnt = 0;
        for (int c = c0 + 1; c <= c0 + 500; c++) if (!txAt(c) || busyAt(c)) cnt++;
        check("t1 non-idle cycles", cnt, 0);
        check("t1 strobes", strobeCount - s0, 0);

        // 2: single entry 0xA5.
        $display("[TB] scenario 2: single byte 0xA5");
        s0 = strobeCount;
        pushByte(8'hA5);
        waitFor(0, 20, "t2 start", st);
        waitFor(1, 200, "t2 done", dn);
        applyStimulus(40);
        check("t2 strobes", strobeCount - s0, 1);
        check("t2 tx before strobe", txAt(st - 1), 1);
        check("t2 tx at strobe", txAt(st), 0);
        check("t2 frame length", dn - st, FRAME1);
        for (int k = 0; k < 10; k++)
            check($sformatf("t2 segment %0d", k), txAt(st + k * CPB + 8), segA5[k]);
        cnt = 0;
        for (int c = st; c < dn; c++) if (busyAt(c)) cnt++;
        check("t2 busy cycles", cnt, FRAME1);
        check("t2 busy after done", busyAt(dn), 0);

        // 3: three queued bytes back to back.
        $display("[TB] scenario 3: three bytes back to back");
        startQ.delete(); doneQ.delete(); decodedQ.delete();
        s0 = strobeCount;
        pushByte(8'h00); pushByte(8'hFF); pushByte(8'h55);
        for (int f = 0; f < 3; f++) waitFor(1, 400, "t3 done", dn);
        applyStimulus(20);
        check("t3 strobes", strobeCount - s0, 3);
        check("t3 fifo empty", fifoEmpty, 1);
        check("t3 decoded count", decodedQ.size(), 3);
        if (decodedQ.size() == 3) begin
            check("t3 byte 0", decodedQ[0], 8'h00);
            check("t3 byte 1", decodedQ[1], 8'hFF);
            check("t3 byte 2", decodedQ[2], 8'h55);
        end
        if (startQ.size() == 3 && doneQ.size() == 3) begin
            check("t3 gap 0", startQ[1] - doneQ[0], 1);
            check("t3 gap 1", startQ[2] - doneQ[1], 1);
        end

        // 4: enable gating.
        $display("[TB] scenario 4: enable gating");
        enable = 1'b0;
        applyStimulus(5);
        pushByte(8'h3A); pushByte(8'h6B);
        s0 = strobeCount; c0 = cycleNo;
        applyStimulus(1000);
        cnt = 0;
        for (int c = c0 + 1; c <= c0 + 1000; c++) if (!txAt(c)) cnt++;
        check("t4 tx low while disabled", cnt, 0);
        check("t4 strobes while disabled", strobeCount - s0, 0);
        enable = 1'b1;
        applyStimulus(1);
        check("t4 start on next edge", fifoRdEn, 1);
        st = cycleNo;
        applyStimulus(50);
        enable = 1'b0;
        waitFor(1, 200, "t4 done", dn);
        check("t4 frame length", dn - st, FRAME1);
        applyStimulus(300);
        check("t4 single pop", strobeCount - s0, 1);
        check("t4 fifo still holds", fifoEmpty, 0);
        enable = 1'b1;
        applyStimulus(1);
        check("t4 restart on next edge", fifoRdEn, 1);
        waitFor(1, 200, "t4 second done", dn);
        applyStimulus(5);

        // 5: reset in the middle of data bit 3.
        $display("[TB] scenario 5: reset mid-frame");
        pushByte(8'h3C);
        waitFor(0, 20, "t5 start", st);
        applyStimulus(70);
        check("t5 busy before reset", busy, 1);
        #2;
        reset = 1'b1;
        #1;
        check("t5 tx on reset", tx, 1);
        check("t5 busy on reset", busy, 0);
        pushByte(8'h81);
        applyStimulus(4);
        reset = 1'b0;
        c0 = cycleNo;
        decodedQ.delete();
        waitFor(0, 20, "t5 restart", st);
        check("t5 restart latency", st - c0, 1);
        waitFor(1, 200, "t5 done", dn);
        applyStimulus(5);
        check("t5 frame length", dn - st, FRAME1);
        cnt = 0;
        for (int c = st; c < st + CPB; c++) if (!txAt(c)) cnt++;
        check("t5 start bit cycles", cnt, CPB);
        check("t5 decoded count", decodedQ.size(), 1);
        if (decodedQ.size() == 1) check("t5 byte", decodedQ[0], 8'h81);

        // 6: two stop bits, byte 0xF0.
        $display("[TB] scenario 6: two stop bits");
        s0 = strobe2Count;
        fifoEmpty2 = 1'b0; enable2 = 1'b1;
        waitFor(2, 20, "t6 start", st);
        enable2 = 1'b0;
        waitFor(3, 300, "t6 done", dn);
        applyStimulus(5);
        check("t6 strobes", strobe2Count - s0, 1);
        check("t6 frame length", dn - st, FRAME2);
        for (int k = 0; k < 9; k++)
            check($sformatf("t6 segment %0d", k), tx2At(st + k * CPB + 8), segF0[k]);
        cnt = 0;
        for (int c = st + 9 * CPB; c < dn; c++) if (tx2At(c)) cnt++;
        check("t6 stop cycles", cnt, 2 * CPB);
        check("t6 busy last stop cycle", busy2At(dn - 1), 1);
        check("t6 busy after done", busy2At(dn), 0);

        // Random traffic with random enable toggling.
        $display("[TB] random traffic");
        decodedQ.delete();
        d0 = doneCount;
        enable = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            applyStimulus(1);
            if ($urandom_range(0, 149) == 0 && (wrIdx - rdIdx) < 200)
                pushByte(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 199) == 0) enable = ~enable;
        end
        enable = 1'b1;
        guard = 0;
        while (!(fifoEmpty && !busy && !mIn) && guard < 6000) begin
            applyStimulus(1);
            guard++;
        end
        applyStimulus(5);
        check("random drain finished", (guard < 6000), 1);
        check("random frames decoded", decodedQ.size(), doneCount - d0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Consumer-side drain for the edge-strobed byte FIFO. It pops one entry at a time with a single-cycle read strobe and serialises each entry as a UART frame: 1 start bit, DATA_WIDTH data bits LSB first, STOP_BITS stop bits, no parity. It sits between the FIFO output and the board TX pin on the 27 MHz Tang Nano 20K clock domain.

Parameters:
CLK_FREQ, 27000000, clock frequency in Hz.
BAUD, 115200, line rate in bit/s.
DATA_WIDTH, 8, data bits per frame; must equal the FIFO data width.
STOP_BITS, 1, number of stop bits (1 or 2).
CLKS_PER_BIT, CLK_FREQ/BAUD (integer divide, 234 at defaults), clocks per bit; must be >= 4.

Ports:
clock  in  1  system clock; all logic on the rising edge.
reset  in  1  asynchronous, active-high reset.
enable  in  1  when high, the block may start new frames.
fifo_empty  in  1  FIFO empty flag.
fifo_data  in  DATA_WIDTH  FIFO head entry; valid whenever fifo_empty=0.
fifo_rd_en  out  1  FIFO read strobe; one-cycle pulse per pop.
tx  out  1  serial line; idle high.
busy  out  1  high from the start bit through the last stop bit.
frame_done  out  1  one-cycle pulse when the last stop bit ends.

Behaviour:
- Interface: reset is asynchronous, active-high; the clock is clock.
- All outputs are registered. Reset values: tx=1, fifo_rd_en=0, busy=0, frame_done=0, state=IDLE, counters=0, shift register=0.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: tx=1, busy=0.
  - If enable=1 and fifo_empty=0 at a clock edge, the block latches fifo_data into the shift register and enters START.
  - At that same edge it sets fifo_rd_en=1, tx=0 and busy=1.
- fifo_rd_en is high for exactly one cycle. It then stays low for at least one full frame, which guarantees the rising edge the FIFO's edge detector needs before the next pop.
- Data is captured before the FIFO pointer advances. The FIFO increments on the edge after it sees the strobe high.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: tx = shift register bit 0. The block shifts right every CLKS_PER_BIT cycles. After DATA_WIDTH bits it enters STOP.
  - Bit counter width is $clog2(DATA_WIDTH).
  - Baud counter width is $clog2(CLKS_PER_BIT). The counter counts 0..CLKS_PER_BIT-1 and reloads 0 at each bit boundary.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - At the edge ending the last stop bit: state=IDLE, busy=0, frame_done=1 for one cycle.
- Frame length is (1+DATA_WIDTH+STOP_BITS)*CLKS_PER_BIT cycles, measured from the tx falling edge to the frame_done edge.
- Back-to-back frames:
  - A minimum of 1 IDLE cycle (tx=1) separates frames.
  - The next tx falling edge occurs 1 cycle after frame_done when the FIFO is non-empty.
- fifo_empty is sampled only in IDLE, so the FIFO's registered count update after a pop is always settled.
- enable deasserted mid-frame: the current frame completes unchanged and no further pop occurs. Reasserting enable in IDLE starts the next frame on the following edge.
- fifo_empty or fifo_data changing mid-frame has no effect.
- Reset mid-frame:
  - Immediate return to reset values; tx goes high asynchronously.
  - The aborted byte has already been popped and is lost.
  - After reset release, operation resumes from IDLE.
- No parity, no flow control, no input buffering beyond the single shift register.

Test Plan:
All scenarios run with CLK_FREQ=1600 and BAUD=100, giving CLKS_PER_BIT=16.
1. Assert reset, then release with fifo_empty=1 and enable=1 -> tx=1, busy=0, fifo_rd_en=0, frame_done=0 for 500 cycles.
2. Behavioural FIFO holding a single entry 0xA5, enable=1 ->
   - exactly one fifo_rd_en pulse, coincident with tx falling;
   - tx sequence of 16-cycle segments: 0,1,0,1,0,0,1,0,1,1;
   - frame_done pulses 160 cycles after tx falls; busy high for those 160 cycles.
3. Real FIFO loaded with 0x00, 0xFF, 0x55 ->
   - three frames decoded by a bench UART monitor as 0x00, 0xFF, 0x55;
   - exactly 1 tx-high idle cycle between frames;
   - exactly 3 strobes; FIFO empty after the third.
4. Non-empty FIFO with enable=0 -> no fifo_rd_en and tx=1 for 1000 cycles. Setting enable=1 starts a frame on the next edge. Dropping enable at data bit 2 -> the frame completes and no second pop occurs.
5. Reset asserted during data bit 3 of 0x3C -> tx=1 and busy=0 immediately. After release, with 0x81 at the FIFO head, the next frame is 0x81 with a full start bit.
6. STOP_BITS=2, byte 0xF0 -> stop phase lasts 32 cycles and frame_done pulses 176 cycles after tx falls.
